// File: rtl/mem_mgr_init_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mem_mgr_pkg : fill-mode encodings, FSM states, SHA-256 K and H0 tables
// Rev 1.0
// ============================================================================
package mem_mgr_pkg;

    localparam logic [1:0] MODE_ZERO = 2'd0;
    localparam logic [1:0] MODE_K    = 2'd1;
    localparam logic [1:0] MODE_H0   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [31:0] SHA256_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] SHA256_H0 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage
`default_nettype wire

// File: rtl/mem_mgr_init_ctrl_if.sv
`default_nettype none
// ============================================================================
// mem_mgr_init_ctrl_if : init handshake plus read/write access bus
// Rev 1.0
// ============================================================================
interface mem_mgr_init_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              init;
    logic [1:0]        init_mode;
    logic              init_complete;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              err;

    modport master (
        output init, init_mode, rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  init_complete, busy, rd_data, rd_valid, err
    );

    modport slave (
        input  init, init_mode, rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output init_complete, busy, rd_data, rd_valid, err
    );
endinterface
`default_nettype wire

// File: rtl/sha256_const_rom.sv
`default_nettype none
// ============================================================================
// sha256_const_rom : combinational (mode, index) -> zero-extended fill word
// Rev 1.0
// ============================================================================
module sha256_const_rom
    import mem_mgr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic [1:0]        mode_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [DATA_W-1:0] word_o
);

    logic [31:0] idx_w;

    always_comb begin
        idx_w  = 32'(idx_i);
        word_o = '0;
        case (mode_i)
            MODE_K: begin
                if (idx_w < 32'd64) word_o = DATA_W'(SHA256_K[idx_w[5:0]]);
            end
            MODE_H0: begin
                if (idx_w < 32'd8) word_o = DATA_W'(SHA256_H0[idx_w[2:0]]);
            end
            default: word_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_mgr_init_ctrl.sv
`default_nettype none
// ============================================================================
// mem_mgr_init_ctrl : word RAM with selectable fill sequence and access port
// Rev 1.0
// ============================================================================
module mem_mgr_init_ctrl
    import mem_mgr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    mem_mgr_init_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [31:0]       DEPTH_U   = 32'(DEPTH);

    state_e            state_q;
    logic              init_prev_q;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_valid_q;
    logic              err_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              init_rise;
    logic              filling;
    logic              rd_ok;
    logic              wr_ok;
    logic              rd_in_range;
    logic              wr_in_range;
    logic [DATA_W-1:0] fill_word;

    assign init_rise = bus.init & ~init_prev_q;
    assign filling   = (state_q == ST_FILL);
    assign rd_ok     = bus.rd_en & ~filling;
    assign wr_ok     = bus.wr_en & ~filling;

    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full_range
            assign rd_in_range = 1'b1;
            assign wr_in_range = 1'b1;
        end else begin : g_partial_range
            assign rd_in_range = (32'(bus.rd_addr) < DEPTH_U);
            assign wr_in_range = (32'(bus.wr_addr) < DEPTH_U);
        end
    endgenerate

    sha256_const_rom #(
        .DATA_W (DATA_W),
        .IDX_W  (ADDR_W)
    ) u_rom (
        .mode_i (mode_q),
        .idx_i  (fill_addr_q),
        .word_o (fill_word)
    );

    // Edge detector keeps sampling through FILL so a held INIT never retriggers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            init_prev_q <= 1'b0;
            mode_q      <= MODE_ZERO;
            fill_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            init_prev_q <= bus.init;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (init_rise) begin
                        state_q     <= ST_FILL;
                        mode_q      <= (bus.init_mode == 2'd3) ? MODE_ZERO : bus.init_mode;
                        fill_addr_q <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (fill_addr_q == LAST_ADDR) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        fill_addr_q <= fill_addr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_in_range) rd_data_d = mem_q[bus.rd_addr];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_ok;
            err_q      <= filling & (bus.rd_en | bus.wr_en);
            if (rd_ok) rd_data_q <= rd_data_d;
        end
    end

    // RAM has no reset; the read above samples the pre-write word on a shared edge.
    always_ff @(posedge clk_i) begin
        if (filling) begin
            mem_q[fill_addr_q] <= fill_word;
        end else if (wr_ok && wr_in_range) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.init_complete = done_q;
    assign bus.busy          = busy_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_mgr_init_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_mgr_init_ctrl : two instances (DEPTH 64 and 16) on shared stimulus,
// compared against a word-level model with a timed expectation queue per DUT
// Rev 1.0
// ============================================================================
module tb_mem_mgr_init_ctrl;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] H0_TAB [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init;
    logic [1:0]  mode;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;

    always #5 clk = ~clk;

    mem_mgr_init_ctrl_if #(.DATA_W(32), .ADDR_W(6)) if64 ();
    mem_mgr_init_ctrl_if #(.DATA_W(32), .ADDR_W(4)) if16 ();

    assign if64.init = init;      assign if16.init = init;
    assign if64.init_mode = mode; assign if16.init_mode = mode;
    assign if64.rd_en = rd_en;    assign if16.rd_en = rd_en;
    assign if64.wr_en = wr_en;    assign if16.wr_en = wr_en;
    assign if64.rd_addr = rd_addr;      assign if16.rd_addr = rd_addr[3:0];
    assign if64.wr_addr = wr_addr;      assign if16.wr_addr = wr_addr[3:0];
    assign if64.wr_data = wr_data;      assign if16.wr_data = wr_data;

    mem_mgr_init_ctrl #(.DATA_W(32), .DEPTH(64)) u_dut64 (
        .clk_i (clk), .rst_n_i (rst_n), .bus (if64.slave)
    );
    mem_mgr_init_ctrl #(.DATA_W(32), .DEPTH(16)) u_dut16 (
        .clk_i (clk), .rst_n_i (rst_n), .bus (if16.slave)
    );

    typedef struct {
        int          cyc;
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] m_mem  [2][64];
    int          m_left [2] = '{0, 0};
    int          m_idx  [2] = '{0, 0};
    int          m_mode [2] = '{0, 0};
    bit          m_done [2] = '{0, 0};
    bit          m_prev [2] = '{0, 0};
    logic [31:0] m_rd   [2] = '{32'h0, 32'h0};
    int          cyc    = 0;
    int          n_vec  = 0;
    int          n_err  = 0;

    function automatic logic [31:0] pat(int md, int i);
        if (md == 1 && i < 64) return K_TAB[i];
        if (md == 2 && i < 8)  return H0_TAB[i];
        return 32'h0;
    endfunction

    task automatic push(int d, bit e, logic [31:0] v);
        exp_t x;
        x.cyc = cyc; x.is_err = e; x.data = v;
        if (d == 0) q0.push_back(x); else q1.push_back(x);
    endtask

    // One clock edge of the reference: a fill owns the RAM, otherwise the port does.
    task automatic model_step(int d);
        int dep, ra, wa;
        bit rise;
        dep  = (d == 0) ? 64 : 16;
        ra   = (d == 0) ? int'(rd_addr) : int'(rd_addr[3:0]);
        wa   = (d == 0) ? int'(wr_addr) : int'(wr_addr[3:0]);
        rise = init && !m_prev[d];
        m_prev[d] = init;
        if (m_left[d] > 0) begin
            if (rd_en || wr_en) push(d, 1'b1, 32'h0);
            m_mem[d][m_idx[d]] = pat(m_mode[d], m_idx[d]);
            m_idx[d]++;
            m_left[d]--;
            if (m_left[d] == 0) m_done[d] = 1'b1;
        end else begin
            if (rd_en) begin
                m_rd[d] = m_mem[d][ra];
                push(d, 1'b0, m_rd[d]);
            end
            if (wr_en) m_mem[d][wa] = wr_data;
            if (rise) begin
                m_mode[d] = int'(mode);
                m_idx[d]  = 0;
                m_left[d] = dep;
                m_done[d] = 1'b0;
            end
        end
    endtask

    always @(negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            m_left[d] = 0; m_done[d] = 1'b0; m_prev[d] = 1'b0; m_rd[d] = 32'h0;
        end
        q0.delete();
        q1.delete();
    end

    always @(posedge clk) begin
        cyc++;
        if (rst_n === 1'b1) begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic check(int d, logic rv, logic [31:0] rdat, logic er, logic bsy, logic cmp);
        exp_t x;
        bit   have;
        have = 1'b0;
        x.cyc = 0; x.is_err = 1'b0; x.data = 32'h0;
        if (d == 0) begin
            if (q0.size() > 0 && q0[0].cyc <= cyc) begin x = q0.pop_front(); have = 1'b1; end
        end else begin
            if (q1.size() > 0 && q1[0].cyc <= cyc) begin x = q1.pop_front(); have = 1'b1; end
        end
        n_vec++;
        if (bsy !== (m_left[d] > 0)) begin
            n_err++;
            $display("FAIL busy dut%0d cyc %0d: got %b want %b", d, cyc, bsy, (m_left[d] > 0));
        end
        n_vec++;
        if (cmp !== m_done[d]) begin
            n_err++;
            $display("FAIL init_complete dut%0d cyc %0d: got %b want %b", d, cyc, cmp, m_done[d]);
        end
        n_vec++;
        if (rv !== (have && !x.is_err)) begin
            n_err++;
            $display("FAIL rd_valid dut%0d cyc %0d: got %b want %b", d, cyc, rv, (have && !x.is_err));
        end
        n_vec++;
        if (er !== (have && x.is_err)) begin
            n_err++;
            $display("FAIL err dut%0d cyc %0d: got %b want %b", d, cyc, er, (have && x.is_err));
        end
        if (have && !x.is_err) begin
            n_vec++;
            if (rdat !== x.data) begin
                n_err++;
                $display("FAIL rd_data dut%0d cyc %0d: got %h want %h", d, cyc, rdat, x.data);
            end
        end else begin
            n_vec++;
            if (rdat !== m_rd[d]) begin
                n_err++;
                $display("FAIL rd_data_hold dut%0d cyc %0d: got %h want %h", d, cyc, rdat, m_rd[d]);
            end
        end
    endtask

    always @(negedge clk) begin
        check(0, if64.rd_valid, if64.rd_data, if64.err, if64.busy, if64.init_complete);
        check(1, if16.rd_valid, if16.rd_data, if16.err, if16.busy, if16.init_complete);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic run(int n, int pct);
        repeat (n) begin
            rd_en   = ($urandom_range(99) < 32'(pct));
            wr_en   = ($urandom_range(99) < 32'(pct));
            rd_addr = 6'($urandom);
            wr_addr = 6'($urandom);
            wr_data = $urandom;
            tick();
        end
        idle();
    endtask

    task automatic read(int a);
        rd_en   = 1'b1;
        rd_addr = 6'(a);
        wr_en   = 1'b0;
        tick();
        rd_en   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; init = 1'b1; mode = 2'd1;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        idle();
        repeat (3) tick();
        rst_n = 1'b1;

        // K fill straight out of reset; colliding access ten cycles in
        repeat (10) tick();
        rd_en = 1'b1; wr_en = 1'b1; rd_addr = 6'd10; wr_addr = 6'd10; wr_data = 32'hcafef00d;
        tick();
        idle();
        repeat (60) tick();
        read(0); read(63); read(10); read(15);
        run(30, 40);

        // H0 fill with a re-edge mid-fill, then INIT held through DONE
        init = 1'b0; tick();
        mode = 2'd2; init = 1'b1; tick();
        repeat (5) tick();
        init = 1'b0; tick();
        init = 1'b1;
        run(70, 0);
        for (int a = 0; a < 16; a++) read(a);

        // zero fill wipes constants; reserved mode behaves the same
        init = 1'b0; tick();
        mode = 2'd0; init = 1'b1; tick();
        run(70, 10);
        read(0); read(7); read(40);
        init = 1'b0; tick();
        mode = 2'd3; init = 1'b1; tick();
        run(70, 10);
        read(1); read(62);

        // reset mid-fill
        init = 1'b0; tick();
        mode = 2'd1; init = 1'b1; tick();
        repeat (20) tick();
        init = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({if64.busy, if64.init_complete, if16.busy, if16.init_complete} !== 4'b0000) begin
            n_err++;
            $display("FAIL async_reset: got %b want 0000",
                     {if64.busy, if64.init_complete, if16.busy, if16.init_complete});
        end
        tick(); tick();
        rst_n = 1'b1;
        run(10, 0);
        init = 1'b1; tick();
        run(70, 20);

        // read-before-write on a shared edge
        rd_en = 1'b1; rd_addr = 6'd5; wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'hdeadbeef;
        tick();
        idle();
        read(5);

        // free-running random traffic with occasional INIT edges
        repeat (400) begin
            if ($urandom_range(99) < 4) begin
                init = ~init;
                mode = 2'($urandom);
            end
            run(1, 40);
        end
        init = 1'b0;
        run(80, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
